// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline payload bundle: control word, PC, operands, shifter/branch fields, flags.
// Pure wiring, no latency of its own.
// No handshake; stage advance is governed by the register's freeze/flush/hazard controls.
interface id_ex_reg_if #(
  parameter int DATA_W = 32
);
  logic [8:0]        ctrl;      // {WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD[3:0]}
  logic [DATA_W-1:0] pc;        // PC+4 of the instruction
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic              imm;
  logic [11:0]       shift_op;
  logic [23:0]       simm24;
  logic [3:0]        dest;
  logic [3:0]        sr;        // {N,Z,C,V}

  // Producer side of the bundle.
  modport master (
    output ctrl, pc, val_rn, val_rm, imm, shift_op, simm24, dest, sr
  );

  // Consumer side of the bundle.
  modport slave (
    input ctrl, pc, val_rn, val_rm, imm, shift_op, simm24, dest, sr
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID->EX pipeline register with bubble insertion, flush and freeze, plus a saturating bubble counter.
// Latency: exactly 1 cycle, every output registered, no input-to-output combinational path.
// Backpressure: freeze holds the whole stage and the counter; flush/hazard/cond-fail insert bubbles.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic             freeze,
  input  logic             flush,
  input  logic             hazard,
  input  logic             cond_pass,
  id_ex_reg_if.slave       id_bus,
  id_ex_reg_if.master      ex_bus,
  output logic             valid_out,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Stage occupancy: the state register is valid_out itself.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_LIVE  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic       bubble;     // instruction enters EX as a no-op (datapath still captured)
  logic       kill_evt;   // a bubble or flush happens on this edge (counted once)
  logic [0:0] state_nxt;

  // Classify the current edge; freeze masks everything.
  always_comb begin
    bubble   = hazard | ~cond_pass;
    kill_evt = ~freeze & (flush | bubble);
  end

  // Next occupancy: only a clean, unfrozen load makes the stage live.
  always_comb begin
    state_nxt = valid_out;
    if (!freeze) begin
      if (flush || bubble) state_nxt = ST_EMPTY;
      else                 state_nxt = ST_LIVE;
    end
  end

  // Occupancy flag and control word; a bubble or flush zeroes the control word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_out   <= ST_EMPTY;
      ex_bus.ctrl <= '0;
    end else if (!freeze) begin
      valid_out   <= state_nxt;
      ex_bus.ctrl <= (flush || bubble) ? 9'h000 : id_bus.ctrl;
    end
  end

  // Datapath fields: captured on load and on bubbles, cleared on flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_bus.pc       <= '0;
      ex_bus.val_rn   <= '0;
      ex_bus.val_rm   <= '0;
      ex_bus.imm      <= 1'b0;
      ex_bus.shift_op <= '0;
      ex_bus.simm24   <= '0;
      ex_bus.dest     <= '0;
      ex_bus.sr       <= '0;
    end else if (!freeze) begin
      if (flush) begin
        ex_bus.pc       <= '0;
        ex_bus.val_rn   <= '0;
        ex_bus.val_rm   <= '0;
        ex_bus.imm      <= 1'b0;
        ex_bus.shift_op <= '0;
        ex_bus.simm24   <= '0;
        ex_bus.dest     <= '0;
        ex_bus.sr       <= '0;
      end else begin
        ex_bus.pc       <= id_bus.pc;
        ex_bus.val_rn   <= id_bus.val_rn;
        ex_bus.val_rm   <= id_bus.val_rm;
        ex_bus.imm      <= id_bus.imm;
        ex_bus.shift_op <= id_bus.shift_op;
        ex_bus.simm24   <= id_bus.simm24;
        ex_bus.dest     <= id_bus.dest;
        ex_bus.sr       <= id_bus.sr;
      end
    end
  end

  // Saturating count of inserted bubbles; reset clears it without counting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (kill_evt && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: table of per-edge vectors on a default-width instance,
// plus a saturation sequence on a CNT_W=2 instance.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_id_ex_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic       rst_a, freeze_a, flush_a, hazard_a, cond_a, valid_a;
  logic [7:0] cnt_a;
  id_ex_reg_if #(.DATA_W(32)) id_a ();
  id_ex_reg_if #(.DATA_W(32)) ex_a ();

  id_ex_reg #(.DATA_W(32), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .freeze(freeze_a), .flush(flush_a), .hazard(hazard_a),
    .cond_pass(cond_a), .id_bus(id_a), .ex_bus(ex_a), .valid_out(valid_a), .bubble_cnt(cnt_a)
  );

  // Instance B: 2-bit counter for saturation.
  logic       rst_b, freeze_b, flush_b, hazard_b, cond_b, valid_b;
  logic [1:0] cnt_b;
  id_ex_reg_if #(.DATA_W(32)) id_b ();
  id_ex_reg_if #(.DATA_W(32)) ex_b ();

  id_ex_reg #(.DATA_W(32), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .freeze(freeze_b), .flush(flush_b), .hazard(hazard_b),
    .cond_pass(cond_b), .id_bus(id_b), .ex_bus(ex_b), .valid_out(valid_b), .bubble_cnt(cnt_b)
  );

  typedef struct {
    logic        rst, freeze, flush, hazard, cond;
    logic [8:0]  ctrl;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest, sr;
  } in_t;

  typedef struct {
    logic [8:0]  ctrl;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest, sr;
    logic        valid;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vec [NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input in_t v);
    rst_a       = v.rst;
    freeze_a    = v.freeze;
    flush_a     = v.flush;
    hazard_a    = v.hazard;
    cond_a      = v.cond;
    id_a.ctrl     = v.ctrl;
    id_a.pc       = v.pc;
    id_a.val_rn   = v.rn;
    id_a.val_rm   = v.rm;
    id_a.imm      = v.imm;
    id_a.shift_op = v.sh;
    id_a.simm24   = v.simm;
    id_a.dest     = v.dest;
    id_a.sr       = v.sr;
  endtask

  task automatic check_a(input int k, input exp_t e);
    chk($sformatf("v%0d ctrl_out", k),     64'(ex_a.ctrl),     64'(e.ctrl));
    chk($sformatf("v%0d pc_out", k),       64'(ex_a.pc),       64'(e.pc));
    chk($sformatf("v%0d val_rn_out", k),   64'(ex_a.val_rn),   64'(e.rn));
    chk($sformatf("v%0d val_rm_out", k),   64'(ex_a.val_rm),   64'(e.rm));
    chk($sformatf("v%0d imm_out", k),      64'(ex_a.imm),      64'(e.imm));
    chk($sformatf("v%0d shift_op_out", k), 64'(ex_a.shift_op), 64'(e.sh));
    chk($sformatf("v%0d simm24_out", k),   64'(ex_a.simm24),   64'(e.simm));
    chk($sformatf("v%0d dest_out", k),     64'(ex_a.dest),     64'(e.dest));
    chk($sformatf("v%0d sr_out", k),       64'(ex_a.sr),       64'(e.sr));
    chk($sformatf("v%0d valid_out", k),    64'(valid_a),       64'(e.valid));
    chk($sformatf("v%0d bubble_cnt", k),   64'(cnt_a),         64'(e.cnt));
  endtask

  initial begin
    // Instance B held in reset while the table runs on instance A.
    rst_b = 1'b0; freeze_b = 1'b0; flush_b = 1'b0; hazard_b = 1'b0; cond_b = 1'b1;
    id_b.ctrl = 9'h1A4; id_b.pc = 32'h100; id_b.val_rn = 32'h1; id_b.val_rm = 32'h2;
    id_b.imm = 1'b0; id_b.shift_op = 12'h0; id_b.simm24 = 24'h0; id_b.dest = 4'h1; id_b.sr = 4'h0;

    //                 rst frz fl hz cp  ctrl    pc        rn         rm         imm sh      simm        dest  sr
    // expected:       ctrl    pc        rn         rm         imm sh      simm        dest  sr    valid cnt
    // Reset with every input nonzero, freeze/flush also high.
    vec[0]  = '{'{0,1,1,1,1, 9'h1FF, 32'hFFFF, 32'hAA,    32'hBB,    1, 12'hABC, 24'h123456, 4'hF, 4'hF},
                '{9'h000, 32'h0,    32'h0,     32'h0,     0, 12'h000, 24'h000000, 4'h0, 4'h0, 0, 8'd0}};
    // Clean load.
    vec[1]  = '{'{1,0,0,0,1, 9'h1A4, 32'h10,   32'h1,     32'h2,     0, 12'h005, 24'h000010, 4'h3, 4'h4},
                '{9'h1A4, 32'h10,   32'h1,     32'h2,     0, 12'h005, 24'h000010, 4'h3, 4'h4, 1, 8'd0}};
    // Condition fail: control zeroed, datapath captured, counted.
    vec[2]  = '{'{1,0,0,0,0, 9'h1FF, 32'h14,   32'h5,     32'h6,     1, 12'h0F0, 24'hFFFFFE, 4'h7, 4'h8},
                '{9'h000, 32'h14,   32'h5,     32'h6,     1, 12'h0F0, 24'hFFFFFE, 4'h7, 4'h8, 0, 8'd1}};
    // Hazard bubble.
    vec[3]  = '{'{1,0,0,1,1, 9'h0A1, 32'h18,   32'h9,     32'hA,     0, 12'h111, 24'h000100, 4'h1, 4'h2},
                '{9'h000, 32'h18,   32'h9,     32'hA,     0, 12'h111, 24'h000100, 4'h1, 4'h2, 0, 8'd2}};
    // Clean load, stage becomes live.
    vec[4]  = '{'{1,0,0,0,1, 9'h123, 32'h20,   32'hDEAD,  32'hBEEF,  1, 12'h7FF, 24'h800000, 4'hA, 4'h5},
                '{9'h123, 32'h20,   32'hDEAD,  32'hBEEF,  1, 12'h7FF, 24'h800000, 4'hA, 4'h5, 1, 8'd2}};
    // Freeze with flush, hazard and cond fail for 3 edges: everything holds.
    for (int k = 5; k <= 7; k++)
      vec[k] = '{'{1,1,1,1,0, 9'h1FF, 32'h999,  32'h77,    32'h88,    0, 12'h3C3, 24'h0F0F0F, 4'h6, 4'h9},
                 '{9'h123, 32'h20,   32'hDEAD,  32'hBEEF,  1, 12'h7FF, 24'h800000, 4'hA, 4'h5, 1, 8'd2}};
    // Flush and hazard together: all zero, counted once.
    vec[8]  = '{'{1,0,1,1,1, 9'h0AA, 32'h24,   32'h11,    32'h22,    1, 12'h222, 24'h000200, 4'h2, 4'h3},
                '{9'h000, 32'h0,    32'h0,     32'h0,     0, 12'h000, 24'h000000, 4'h0, 4'h0, 0, 8'd3}};
    // Clean load again.
    vec[9]  = '{'{1,0,0,0,1, 9'h0C3, 32'h30,   32'h33,    32'h44,    0, 12'h333, 24'h000300, 4'h4, 4'h6},
                '{9'h0C3, 32'h30,   32'h33,    32'h44,    0, 12'h333, 24'h000300, 4'h4, 4'h6, 1, 8'd3}};
    // Reset while frozen and flushing: clears everything, counter to 0.
    vec[10] = '{'{0,1,1,0,1, 9'h1FF, 32'h35,   32'h55,    32'h66,    1, 12'h444, 24'h000400, 4'h5, 4'h7},
                '{9'h000, 32'h0,    32'h0,     32'h0,     0, 12'h000, 24'h000000, 4'h0, 4'h0, 0, 8'd0}};
    // First edge after reset: normal load, reset was not counted.
    vec[11] = '{'{1,0,0,0,1, 9'h055, 32'h40,   32'h77,    32'h99,    1, 12'h555, 24'h000500, 4'h9, 4'h1},
                '{9'h055, 32'h40,   32'h77,    32'h99,    1, 12'h555, 24'h000500, 4'h9, 4'h1, 1, 8'd0}};
    // Flush alone with a passing instruction.
    vec[12] = '{'{1,0,1,0,1, 9'h1F0, 32'h44,   32'h1,     32'h2,     1, 12'h666, 24'h000600, 4'h8, 4'h2},
                '{9'h000, 32'h0,    32'h0,     32'h0,     0, 12'h000, 24'h000000, 4'h0, 4'h0, 0, 8'd1}};

    // Table: drive, clock, sample 1 unit after the edge.
    for (int k = 0; k < NVEC; k++) begin
      drive_a(vec[k].i);
      @(posedge clk);
      #1;
      check_a(k, vec[k].e);
    end

    // Saturation on the 2-bit counter: reset, then 5 hazard edges.
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    chk("sat reset bubble_cnt", 64'(cnt_b), 64'd0);
    chk("sat reset valid_out", 64'(valid_b), 64'd0);

    rst_b    = 1'b1;
    hazard_b = 1'b1;
    begin
      logic [1:0] sat_exp [5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        chk($sformatf("sat edge%0d bubble_cnt", k + 1), 64'(cnt_b), 64'(sat_exp[k]));
        chk($sformatf("sat edge%0d valid_out", k + 1), 64'(valid_b), 64'd0);
        chk($sformatf("sat edge%0d ctrl_out", k + 1), 64'(ex_b.ctrl), 64'd0);
      end
    end

    // A clean load after saturation: live again, counter stays pinned.
    hazard_b = 1'b0;
    @(posedge clk);
    #1;
    chk("sat load ctrl_out", 64'(ex_b.ctrl), 64'h1A4);
    chk("sat load pc_out", 64'(ex_b.pc), 64'h100);
    chk("sat load valid_out", 64'(valid_b), 64'd1);
    chk("sat load bubble_cnt", 64'(cnt_b), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
